// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands in a FIFO and issues them one at a time, capturing each result.
// Optional wait timeout with error result: define ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic [3:0]           cmd_fun,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_fun,
  input  logic [2*WIDTH:0]     arith_out,
  input  logic [WIDTH-1:0]     logic_out,
  input  logic [WIDTH-1:0]     cmp_out,
  input  logic [WIDTH-1:0]     shift_out,
  input  logic                 arith_flag,
  input  logic                 logic_flag,
  input  logic                 cmp_flag,
  input  logic                 shift_flag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH:0]     res_data,
  output logic [3:0]           res_fun,
  output logic                 res_err
);

  localparam int RW = 2*WIDTH+1;
  localparam int CW = $clog2(TIMEOUT+1);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2*WIDTH+4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]      r_alu_fun;
  logic            r_res_valid;
  logic [RW-1:0]   r_res_data;
  logic [3:0]      r_res_fun;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;
  logic          w_flag;
  logic [RW-1:0] w_out;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign cmd_ready = !rst && !w_full;
  assign w_push  = cmd_valid && cmd_ready;
  // Pop only from registered occupancy, so a fresh push waits a cycle.
  assign w_pop   = !w_empty &&
                   ((r_state == S_IDLE) ||
                    (r_state == S_HOLD && res_ready));
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {cmd_a, cmd_b, cmd_fun};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_flag = 1'b0;
    w_out  = '0;
    unique case (r_alu_fun[3:2])
      2'b00: begin w_flag = arith_flag; w_out = arith_out; end
      2'b01: begin w_flag = logic_flag; w_out = {{(WIDTH+1){1'b0}}, logic_out}; end
      2'b10: begin w_flag = cmp_flag;   w_out = {{(WIDTH+1){1'b0}}, cmp_out}; end
      default: begin w_flag = shift_flag; w_out = {{(WIDTH+1){1'b0}}, shift_out}; end
    endcase
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  logic r_res_err;
  assign res_err = r_res_err;
`else
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_fun   <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      r_res_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_alu_a, r_alu_b, r_alu_fun} <= w_head;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A flag seen at count 0 belongs to the previous command.
          if (r_cnt != '0 && w_flag) begin
            r_res_data  <= w_out;
            r_res_fun   <= r_alu_fun;
            r_res_valid <= 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
            r_res_err   <= 1'b0;
`endif
            r_state     <= S_HOLD;
`ifdef ALU_SEQ_TIMEOUT_EN
          end else if (r_cnt == CW'(TIMEOUT-1)) begin
            r_res_data  <= '0;
            r_res_fun   <= r_alu_fun;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b1;
            r_state     <= S_HOLD;
`endif
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              {r_alu_a, r_alu_b, r_alu_fun} <= w_head;
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_fun   = r_alu_fun;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_fun   = r_res_fun;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural registered ALU plus a result scoreboard.
// Timeout scenario runs only when ALU_SEQ_TIMEOUT_EN is defined.
module tb_alu_op_sequencer;

  localparam int W  = 16;
  localparam int RW = 2*W+1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_a = '0;
  logic [W-1:0]  cmd_b = '0;
  logic [3:0]    cmd_fun = '0;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [3:0]    alu_fun;
  logic [RW-1:0] arith_out = '0;
  logic [W-1:0]  logic_out = '0;
  logic [W-1:0]  cmp_out = '0;
  logic [W-1:0]  shift_out = '0;
  logic          arith_flag = 1'b0;
  logic          logic_flag = 1'b0;
  logic          cmp_flag = 1'b0;
  logic          shift_flag = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [RW-1:0] res_data;
  logic [3:0]    res_fun;
  logic          res_err;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .arith_out(arith_out), .logic_out(logic_out),
    .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag),
    .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_fun(res_fun), .res_err(res_err)
  );

  logic force0 = 1'b0;

  // Free-running registered ALU model.
  always @(posedge clk) begin
    logic signed [RW-1:0] sa, sb;
    sa = RW'($signed(alu_a));
    sb = RW'($signed(alu_b));
    case (alu_fun[1:0])
      2'b00:   arith_out <= sa + sb;
      2'b01:   arith_out <= sa - sb;
      default: arith_out <= sa * sb;
    endcase
    case (alu_fun[1:0])
      2'b00:   logic_out <= alu_a & alu_b;
      2'b01:   logic_out <= alu_a | alu_b;
      default: logic_out <= alu_a ^ alu_b;
    endcase
    cmp_out   <= {15'd0, alu_a == alu_b};
    shift_out <= alu_a << alu_b[3:0];
    arith_flag <= !force0 && alu_fun[3:2] == 2'b00;
    logic_flag <= !force0 && alu_fun[3:2] == 2'b01;
    cmp_flag   <= !force0 && alu_fun[3:2] == 2'b10;
    shift_flag <= !force0 && alu_fun[3:2] == 2'b11;
  end

  typedef struct packed {
    logic [RW-1:0] d;
    logic [3:0]    f;
    logic          e;
  } res_t;

  res_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] f, input logic [RW-1:0] d);
    bit ok;
    ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_fun = f; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (cmd_ready) begin
        q.push_back('{d, f, force0});
        ok = 1'b1;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_accept got=not_accepted exp=accepted fun=%b", f);
    end
  endtask

  task automatic get(output res_t got, output res_t exp,
                     output bit ok, output int k);
    ok = 1'b0;
    k = 0;
    got = '0;
    exp = '1;
    res_ready = 1'b1;
    while (!ok && k < 100) begin
      if (res_valid) begin
        got = '{res_data, res_fun, res_err};
        ok = 1'b1;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (ok && q.size() > 0) exp = q.pop_front();
    if (ok) @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, res_valid, res_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000", {cmd_ready, res_valid, res_err});
    end
    checks++;
    if ({alu_a, alu_b, alu_fun} !== '0) begin
      failures++;
      $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_fun});
    end
    checks++;
    if ({res_data, res_fun} !== '0) begin
      failures++;
      $display("FAIL reset_res got=%h exp=0", {res_data, res_fun});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_single;
    res_t g, e;
    bit ok;
    int k;
    send(16'h0005, 16'h0003, 4'b0000, 33'd8);
    get(g, e, ok, k);
    checks++;
    if (!ok || k != 3) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=3", k);
    end
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL single_result got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_units;
    res_t g, e;
    bit ok;
    int k;
    send(16'hF0F0, 16'hFF00, 4'b0100, 33'h0_0000_F000);
    send(16'h0001, 16'h0004, 4'b1100, 33'h0_0000_0010);
    for (int i = 0; i < 2; i++) begin
      get(g, e, ok, k);
      checks++;
      if (!ok || g !== e) begin
        failures++;
        $display("FAIL units_result%0d got=%h exp=%h", i, g, e);
      end
      checks++;
      if (g.d[RW-1:W] !== '0) begin
        failures++;
        $display("FAIL units_zext%0d got=%h exp=0", i, g.d[RW-1:W]);
      end
    end
  endtask

  task automatic test_backpressure;
    res_t g, e;
    bit ok;
    int k;
    logic [RW+3:0] snap;
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      send(W'(10*i), W'(i), 4'b0000, RW'(11*i));
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full got=%b exp=0", cmd_ready);
    end
    snap = {res_data, res_fun};
    repeat (4) @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || {res_data, res_fun} !== snap ||
        cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold got=%b/%h exp=1/%h", res_valid,
               {res_data, res_fun}, snap);
    end
    for (int i = 0; i < 5; i++) begin
      get(g, e, ok, k);
      checks++;
      if (!ok || g !== e) begin
        failures++;
        $display("FAIL bp_drain%0d got=%h exp=%h", i, g, e);
      end
      if (i > 0) begin
        checks++;
        if (k != 2) begin
          failures++;
          $display("FAIL bp_throughput%0d got=%0d exp=2", i, k);
        end
      end
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_after got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_same_unit;
    res_t g, e;
    bit ok;
    int k;
    send(16'd1, 16'd1, 4'b0000, 33'd2);
    send(16'd2, 16'd2, 4'b0000, 33'd4);
    for (int i = 0; i < 2; i++) begin
      get(g, e, ok, k);
      checks++;
      if (!ok || g !== e) begin
        failures++;
        $display("FAIL same_unit%0d got=%h exp=%h", i, g, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    res_ready = 1'b0;
    send(16'd3, 16'd4, 4'b0000, 33'd7);
    send(16'd5, 16'd6, 4'b0000, 33'd11);
    send(16'd7, 16'd8, 4'b0000, 33'd15);
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, res_valid, res_err, alu_fun, alu_a, alu_b} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got=%h exp=0",
               {cmd_ready, res_valid, res_err, alu_fun, alu_a, alu_b});
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    res_ready = 1'b0;
    checks++;
    if (seen !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_no_result got=%b/%b exp=0/1", seen, cmd_ready);
    end
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    res_t g, e;
    bit ok;
    int k;
    force0 = 1'b1;
    send(16'h1234, 16'h00FF, 4'b0100, 33'd0);
    get(g, e, ok, k);
    checks++;
    if (!ok || g !== e || g.e !== 1'b1) begin
      failures++;
      $display("FAIL timeout_result got=%h exp=%h", g, e);
    end
    force0 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_units();
    test_backpressure();
    test_same_unit();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command sequencer directly upstream of the 16-bit signed ALU top level. It buffers operand/function commands in a small FIFO and drives `A`, `B` and `ALU_FUN` into the ALU one command at a time. It waits for the selected unit's flag, captures that unit's output, and presents it as a zero-extended result with a valid/ready handshake. This turns the free-running, registered ALU into a flow-controlled, back-pressurable operation stream.

## Interface
- `WIDTH`, 16, operand width; must match the ALU.
- `DEPTH`, 4, command FIFO depth; power of two, ≥2.
- `TIMEOUT`, 8, maximum WAIT cycles before an error result (only with the timeout feature).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_a`, `cmd_b` in WIDTH: signed operands.
- `cmd_fun` in 4: ALU function code; [3:2] selects the unit (00 arith, 01 logic, 10 cmp, 11 shift).
- `alu_a`, `alu_b` out WIDTH: registered drive to ALU `A`/`B`.
- `alu_fun` out 4: registered drive to `ALU_FUN`.
- `arith_out` in 2*WIDTH+1; `logic_out`, `cmp_out`, `shift_out` in WIDTH: ALU results.
- `arith_flag`, `logic_flag`, `cmp_flag`, `shift_flag` in 1: ALU unit-valid flags.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 2*WIDTH+1: captured result.
- `res_fun` out 4: function code that produced `res_data`.
- `res_err` out 1: result was produced by a timeout; `res_data` = 0.

## Operation
- FIFO push on `cmd_valid & cmd_ready`. `cmd_ready = !full`, computed from registered occupancy only; a same-cycle pop does not raise it.
- A command is never pushed and popped in the same cycle it arrives.
- FSM states:
  - IDLE: FIFO non-empty → pop, load `alu_a/alu_b/alu_fun`, clear wait counter, go to WAIT.
  - WAIT: wait counter increments each cycle. The selected flag is ignored while the counter is 0 (stale-flag guard). With counter ≥1 and the selected flag high → capture, go to HOLD.
  - HOLD: `res_valid` = 1, and all `res_*` outputs are stable. On `res_ready`: if FIFO non-empty, pop and load the next command straight into WAIT; otherwise go to IDLE.
- Selected flag/output per `alu_fun[3:2]`: 00 arith, 01 logic, 10 cmp, 11 shift.
- Non-arith outputs are zero-extended to 2*WIDTH+1. Arith is captured unmodified.
- `alu_*` registers hold their last command while in IDLE and HOLD.
- Reset mid-operation: FIFO empties, FSM goes to IDLE, and any in-flight command is dropped with no result.

## Timing
- Reset values: `cmd_ready` = 1 once reset is released (0 while `rst` is high); `alu_a`/`alu_b`/`alu_fun` = 0; `res_valid` = 0, `res_data` = 0, `res_fun` = 0, `res_err` = 0.
- Latency, FIFO empty and FSM in IDLE. Command accepted at edge E0.
  - E1: pop, ALU drive regs loaded.
  - E2: ALU registers its output.
  - E3: capture; `res_valid` is high from E3.
- Latency from acceptance to `res_valid` is 3 cycles.
- Steady-state throughput with `res_ready` held at 1 is one result per 3 cycles (HOLD → WAIT → WAIT → HOLD).
- `res_valid` drops in the cycle after the handshake edge unless a new result is captured.

## Configuration
- `ALU_SEQ_TIMEOUT_EN` defined: if the wait counter reaches `TIMEOUT` in WAIT without the flag, go to HOLD with `res_err` = 1, `res_data` = 0, and `res_fun` = the issued code.
- Not defined: WAIT waits indefinitely. The counter only implements the stale-flag guard, and `res_err` is tied to 0.

## Test plan
- Single op: A=0x0005, B=0x0003, FUN=0000 (add), `res_ready` = 1 → `res_valid` 3 cycles after accept; `res_data` = 8, `res_fun` = 0000, `res_err` = 0.
- Unit select and zero-extension: push 0100 (AND, A=0xF0F0, B=0xFF00), then 1100 (shift) → two results in order; `res_data` = 0x0_0000_F000 for the AND; upper WIDTH+1 bits 0 for both.
- Back-pressure and full: hold `res_ready` = 0, push 5 commands with DEPTH=4 → 4 accepted after the first pops; `cmd_ready` = 0 when full; the result holds stable; releasing `res_ready` drains all results in push order.
- Same-unit consecutive ops (two adds, 1+1 then 2+2) → the second result is 4, never a stale 2.
- Timeout, macro defined: force all flags to 0 → after `TIMEOUT` WAIT cycles, `res_valid` = 1, `res_err` = 1, `res_data` = 0.
- Assert `rst` during WAIT with 2 commands queued → all outputs at reset values immediately; no result is produced after release.
